// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: 2-flop synchronized receiver with mid-bit sampling and a registered-output transmitter.
// RX strobes rx_valid ~2+9.5 bit periods after the start edge; TX ignores tx_flag while tx_done is low.
module uart_transceiver #(
  parameter int CLK_FREQ  = 65_000_000,
  parameter int BAUT_RATE = 115200
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] din,
  input  logic       tx_flag,
  output logic       txd,
  output logic       tx_done
);

  localparam int BIT_CNT = CLK_FREQ / BAUT_RATE;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(BIT_CNT / 2);
  localparam logic [CW-1:0] CNT_SYNC = CW'(2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t       rx_state;
  logic            rxd_s1, rxd_s2, rxd_d;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;

  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic [9:0]      tx_shift;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_d    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_d    <= rxd_s2;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // Start counting at 2: the synchronizer has already eaten two cycles of the start bit.
          if (rxd_d && !rxd_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= CNT_SYNC;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_MID) begin
            if (rxd_s2) begin
              rx_state <= RX_IDLE;
              rx_cnt   <= '0;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= '0;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so a start bit directly behind it is still caught.
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rxd_s2) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      txd      <= 1'b1;
      tx_done  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_flag) begin
            tx_shift <= {1'b1, din, 1'b0};
            txd      <= 1'b0;
            tx_done  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              txd      <= 1'b1;
              tx_done  <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_bit   <= tx_bit + 4'd1;
              txd      <= tx_shift[1];
              tx_shift <= {1'b1, tx_shift[9:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Randomized bench for uart_transceiver at 10 clocks per bit; frames are modelled as bit lists over time.
module tb_uart_transceiver;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rxd_line;
  logic [7:0] din = 8'h00;
  logic       tx_flag = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       txd;
  logic       tx_done;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned last_valid_cyc = 0;
  logic [7:0]  rx_got[$];
  logic [7:0]  rx_exp[$];
  logic [7:0]  exp_rx_data = 8'h00;

  assign rxd_line = loop_en ? txd : rxd_drv;

  uart_transceiver #(.CLK_FREQ(1_000_000), .BAUT_RATE(100_000)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .rxd       (rxd_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .din       (din),
    .tx_flag   (tx_flag),
    .txd       (txd),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sys_rst_n && rx_valid) begin
      rx_got.push_back(rx_data);
      last_valid_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the flag is taken on the next rising edge and the line is
  // compared every cycle against the frame's ten bits of ten cycles each.
  task automatic tx_frame(input logic [7:0] b, input bit poke);
    logic [9:0] fr;
    int         wave_err;
    fr       = {1'b1, b, 1'b0};
    wave_err = 0;
    din      = b;
    tx_flag  = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k < 100 && (txd !== fr[k/10] || tx_done !== 1'b0)) wave_err++;
      if (k % 10 == 5) check($sformatf("tx_%02h_bit%0d", b, k / 10), 32'(txd), 32'(fr[k/10]));
      if (k == 99) check("tx_done_busy", 32'(tx_done), 32'd0);
      if (k == 0) begin
        tx_flag = 1'b0;
        din     = 8'($urandom);
      end
      if (poke && k == 40) begin
        tx_flag = 1'b1;
        din     = 8'hFF;
      end
      if (poke && k == 41) tx_flag = 1'b0;
    end
    check("tx_done_end", 32'(tx_done), 32'd1);
    check("tx_idle_line", 32'(txd), 32'd1);
    check($sformatf("tx_%02h_wave_errs", b), 32'(wave_err), 32'd0);
  endtask

  // len_x100 is the sender's bit length in hundredths of a cycle (1000 = exact baud).
  task automatic rx_send(input logic [7:0] b, input bit stop_bit, input int len_x100);
    logic [9:0] fr;
    int         n;
    int         idx;
    fr = {stop_bit, b, 1'b0};
    n  = (10 * len_x100 + 99) / 100;
    for (int c = 0; c < n; c++) begin
      idx = c * 100 / len_x100;
      if (idx > 9) idx = 9;
      rxd_drv = fr[idx];
      if (c == 0) start_cyc = cyc;
      @(negedge clk);
    end
    rxd_drv = 1'b1;
    if (stop_bit) begin
      rx_exp.push_back(b);
      exp_rx_data = b;
    end
  endtask

  task automatic rx_check(input string tag);
    logic [7:0] g;
    logic [7:0] e;
    check({tag, "_count"}, 32'(rx_got.size()), 32'(rx_exp.size()));
    while (rx_got.size() > 0 && rx_exp.size() > 0) begin
      g = rx_got.pop_front();
      e = rx_exp.pop_front();
      check({tag, "_byte"}, 32'(g), 32'(e));
    end
    rx_got.delete();
    rx_exp.delete();
    check({tag, "_hold"}, 32'(rx_data), 32'(exp_rx_data));
  endtask

  initial begin
    int          lat;
    logic [7:0]  b;
    bit          ok;

    idle(2);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_done", 32'(tx_done), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    sys_rst_n = 1'b1;
    idle(3);

    tx_frame(8'h55, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom), 1'b0);

    rx_send(8'hA5, 1'b1, 1000);
    idle(5);
    lat = int'(last_valid_cyc - start_cyc);
    check($sformatf("rx_latency_%0d_in_96_98", lat), 32'(lat >= 96 && lat <= 98), 32'd1);
    rx_check("rx_a5");

    rxd_drv = 1'b0;
    idle(3);
    rxd_drv = 1'b1;
    idle(20);
    rx_check("rx_glitch");

    rx_send(8'($urandom), 1'b0, 1000);
    idle(20);
    rx_check("rx_frame_err");

    for (int burst = 0; burst < 3; burst++) begin
      for (int f = 0; f < 8; f++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 5) != 0);
        rx_send(b, ok, $urandom_range(970, 1030));
        idle(ok ? $urandom_range(0, 2) : $urandom_range(2, 3));
      end
      idle(5);
      rx_check($sformatf("rx_stream%0d", burst));
    end

    loop_en = 1'b1;
    idle(2);
    tx_frame(8'h3C, 1'b0);
    tx_frame(8'hC3, 1'b0);
    rx_exp.push_back(8'h3C);
    rx_exp.push_back(8'hC3);
    exp_rx_data = 8'hC3;
    idle(10);
    rx_check("loopback");
    loop_en = 1'b0;
    idle(2);

    din     = 8'($urandom);
    tx_flag = 1'b1;
    @(negedge clk);
    tx_flag = 1'b0;
    idle(34);
    check("busy_before_rst", 32'(tx_done), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_tx_done", 32'(tx_done), 32'd1);
    check("rst_mid_rx_data", 32'(rx_data), 32'h00);
    exp_rx_data = 8'h00;
    @(negedge clk);
    sys_rst_n = 1'b1;
    idle(3);
    tx_frame(8'h81, 1'b0);
    idle(5);
    rx_check("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
